// File: rtl/spi_target_if.sv
// Pin-side and byte-side signals of the SPI mode-0 target front end.
// The TX signals exist only when SPI_CIPO_EN is defined.
interface spi_target_if;
    logic       spi_sck_i;
    logic       spi_copi_i;
    logic       spi_cs_i;
    logic [7:0] rx_byte_o;
    logic       rx_valid_o;
    logic       rx_first_o;
    logic       cs_start_o;
    logic       cs_end_o;
`ifdef SPI_CIPO_EN
    logic [7:0] tx_byte_i;
    logic       tx_ready_o;
    logic       spi_cipo_o;

    modport master (
        output spi_sck_i, spi_copi_i, spi_cs_i, tx_byte_i,
        input  rx_byte_o, rx_valid_o, rx_first_o, cs_start_o, cs_end_o,
               tx_ready_o, spi_cipo_o
    );

    modport slave (
        input  spi_sck_i, spi_copi_i, spi_cs_i, tx_byte_i,
        output rx_byte_o, rx_valid_o, rx_first_o, cs_start_o, cs_end_o,
               tx_ready_o, spi_cipo_o
    );
`else
    modport master (
        output spi_sck_i, spi_copi_i, spi_cs_i,
        input  rx_byte_o, rx_valid_o, rx_first_o, cs_start_o, cs_end_o
    );

    modport slave (
        input  spi_sck_i, spi_copi_i, spi_cs_i,
        output rx_byte_o, rx_valid_o, rx_first_o, cs_start_o, cs_end_o
    );
`endif
endinterface

// File: rtl/spi_target.sv
// SPI mode-0 target: synchronises SCK/COPI/CS into clk, frames whole bytes, strobes bytes and CS edges.
// Optional SPI_CIPO_EN macro adds a TX shifter driving spi_cipo_o.
module spi_target #(
    parameter int SYNC_STAGES = 2,
    parameter bit MSB_FIRST   = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    spi_target_if.slave bus
);

    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync_stages
        $error("spi_target: SYNC_STAGES must be in 2..4");
    end

    typedef enum logic {IDLE, ACTIVE} state_t;

    logic [SYNC_STAGES-1:0] sck_sync;
    logic [SYNC_STAGES-1:0] copi_sync;
    logic [SYNC_STAGES-1:0] cs_sync;
    logic                   sck_q;
    logic                   cs_q;

    logic sck_s;
    logic copi_s;
    logic cs_s;
    logic sck_rise;
    logic cs_fall;
    logic cs_rise;

    // NOTE: CS resets to its idle level (1) so leaving reset never looks like a select.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sck_sync  <= '0;
            copi_sync <= '0;
            cs_sync   <= '1;
            sck_q     <= 1'b0;
            cs_q      <= 1'b1;
        end else begin
            // NOTE: non-blocking so every stage samples its predecessor's old value in the same edge.
            sck_sync  <= {sck_sync[SYNC_STAGES-2:0], bus.spi_sck_i};
            copi_sync <= {copi_sync[SYNC_STAGES-2:0], bus.spi_copi_i};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], bus.spi_cs_i};
            sck_q     <= sck_sync[SYNC_STAGES-1];
            cs_q      <= cs_sync[SYNC_STAGES-1];
        end
    end

    assign sck_s    = sck_sync[SYNC_STAGES-1];
    assign copi_s   = copi_sync[SYNC_STAGES-1];
    assign cs_s     = cs_sync[SYNC_STAGES-1];
    assign sck_rise = sck_s & ~sck_q;
    assign cs_fall  = ~cs_s & cs_q;
    assign cs_rise  = cs_s & ~cs_q;

    state_t     state;
    logic [2:0] bit_cnt;
    logic [7:0] rx_shift;
    logic [7:0] rx_next;
    logic       first_flag;
    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       rx_first;
    logic       cs_start;
    logic       cs_end;

    assign rx_next = MSB_FIRST ? {rx_shift[6:0], copi_s} : {copi_s, rx_shift[7:1]};

`ifdef SPI_CIPO_EN
    logic       sck_fall;
    logic [7:0] tx_shift;
    logic       tx_reload;
    logic       tx_ready;

    assign sck_fall = ~sck_s & sck_q;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            bit_cnt    <= 3'd0;
            rx_shift   <= 8'h00;
            first_flag <= 1'b0;
            rx_byte    <= 8'h00;
            rx_valid   <= 1'b0;
            rx_first   <= 1'b0;
            cs_start   <= 1'b0;
            cs_end     <= 1'b0;
`ifdef SPI_CIPO_EN
            tx_shift   <= 8'h00;
            tx_reload  <= 1'b0;
            tx_ready   <= 1'b0;
`endif
        end else begin
            rx_valid <= 1'b0;
            rx_first <= 1'b0;
            cs_start <= 1'b0;
            cs_end   <= 1'b0;
`ifdef SPI_CIPO_EN
            tx_ready <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    // SCK edges are ignored here, including one coinciding with the CS fall.
                    if (cs_fall) begin
                        state      <= ACTIVE;
                        cs_start   <= 1'b1;
                        bit_cnt    <= 3'd0;
                        first_flag <= 1'b1;
`ifdef SPI_CIPO_EN
                        tx_shift   <= bus.tx_byte_i;
                        tx_reload  <= 1'b0;
                        tx_ready   <= 1'b1;
`endif
                    end
                end
                ACTIVE: begin
                    // CS deassert takes priority over a coincident SCK edge; partial bytes are dropped.
                    if (cs_rise) begin
                        state   <= IDLE;
                        cs_end  <= 1'b1;
                        bit_cnt <= 3'd0;
`ifdef SPI_CIPO_EN
                        tx_shift  <= 8'h00;
                        tx_reload <= 1'b0;
`endif
                    end else if (sck_rise) begin
                        rx_shift <= rx_next;
                        bit_cnt  <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            rx_byte    <= rx_next;
                            rx_valid   <= 1'b1;
                            rx_first   <= first_flag;
                            first_flag <= 1'b0;
`ifdef SPI_CIPO_EN
                            tx_reload  <= 1'b1;
`endif
                        end
                    end
`ifdef SPI_CIPO_EN
                    else if (sck_fall) begin
                        if (tx_reload) begin
                            tx_shift  <= bus.tx_byte_i;
                            tx_reload <= 1'b0;
                            tx_ready  <= 1'b1;
                        end else if (MSB_FIRST) begin
                            tx_shift <= {tx_shift[6:0], 1'b0};
                        end else begin
                            tx_shift <= {1'b0, tx_shift[7:1]};
                        end
                    end
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.rx_byte_o  = rx_byte;
    assign bus.rx_valid_o = rx_valid;
    assign bus.rx_first_o = rx_first;
    assign bus.cs_start_o = cs_start;
    assign bus.cs_end_o   = cs_end;
`ifdef SPI_CIPO_EN
    assign bus.tx_ready_o = tx_ready;
    assign bus.spi_cipo_o = MSB_FIRST ? tx_shift[7] : tx_shift[0];
`endif

endmodule

// File: tb/tb_spi_target.sv
// Self-checking bench for spi_target: table of transactions plus hand-written reset,
// CS/SCK-collision and (with SPI_CIPO_EN) transmit sequences.
module tb_spi_target;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    spi_target_if bus();

    spi_target #(.SYNC_STAGES(2), .MSB_FIRST(1'b1)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    typedef struct packed {
        logic [7:0] data;
        logic       first;
    } strobe_t;

    typedef struct {
        logic [15:0] data;        // byte 0 in [15:8], byte 1 in [7:0]
        int          nbytes;
        int          partial_bits;
        int          exp_strobes;
        logic [7:0]  exp_hold;
    } vec_t;

    strobe_t strobes[$];
    int n_start;
    int n_end;
    int n_ready;
    int n_orphan_first;
    int n_checks;
    int n_errors;

    // Observe outputs on the falling clk edge, away from the DUT's active edge.
    always @(negedge clk) begin
        if (bus.rx_valid_o === 1'b1) strobes.push_back({bus.rx_byte_o, bus.rx_first_o});
        if (bus.rx_first_o === 1'b1 && bus.rx_valid_o !== 1'b1) n_orphan_first++;
        if (bus.cs_start_o === 1'b1) n_start++;
        if (bus.cs_end_o === 1'b1) n_end++;
`ifdef SPI_CIPO_EN
        if (bus.tx_ready_o === 1'b1) n_ready++;
`endif
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_monitor();
        strobes.delete();
        n_start = 0;
        n_end   = 0;
        n_ready = 0;
    endtask

    // One mode-0 bit: data set while SCK low, SCK high for 4 clk; CIPO sampled at the rising pin edge.
    task automatic send_bit(input logic b, output logic cipo_seen);
        bus.spi_copi_i = b;
        wait_clk(4);
        bus.spi_sck_i = 1'b1;
`ifdef SPI_CIPO_EN
        cipo_seen = bus.spi_cipo_o;
`else
        cipo_seen = 1'b0;
`endif
        wait_clk(4);
        bus.spi_sck_i = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] d, output logic [7:0] rd);
        logic c;
        rd = 8'h00;
        for (int i = 7; i >= 0; i--) begin
            send_bit(d[i], c);
            rd = {rd[6:0], c};
        end
    endtask

    vec_t vecs[4];

    initial begin
        logic [7:0] rd;
        logic [7:0] rd2;
        logic       c;
        logic [7:0] exp_b;

        n_checks = 0;
        n_errors = 0;
        n_orphan_first = 0;

        vecs[0] = '{16'hA500, 1, 0, 1, 8'hA5};
        vecs[1] = '{16'h3CFF, 2, 0, 2, 8'hFF};
        vecs[2] = '{16'h0000, 0, 5, 0, 8'hFF};
        vecs[3] = '{16'h8100, 1, 0, 1, 8'h81};

        bus.spi_sck_i  = 1'b0;
        bus.spi_copi_i = 1'b0;
        bus.spi_cs_i   = 1'b1;
`ifdef SPI_CIPO_EN
        bus.tx_byte_i  = 8'h00;
`endif
        reset = 1'b1;
        wait_clk(3);
        reset = 1'b0;
        clear_monitor();

        // Idle: CS high with SCK toggling must produce nothing.
        for (int i = 0; i < 8; i++) send_bit(1'b1, c);
        wait_clk(20);
        check("idle_rx_byte",  {24'd0, bus.rx_byte_o}, 32'h00);
        check("idle_rx_valid", {31'd0, bus.rx_valid_o}, 32'd0);
        check("idle_rx_first", {31'd0, bus.rx_first_o}, 32'd0);
        check("idle_strobes",  strobes.size(), 32'd0);
        check("idle_cs_start", n_start, 32'd0);
        check("idle_cs_end",   n_end, 32'd0);
`ifdef SPI_CIPO_EN
        check("idle_tx_ready", n_ready, 32'd0);
        check("idle_cipo",     {31'd0, bus.spi_cipo_o}, 32'd0);
`endif

        // Table-driven transactions, CS high 10 clk between them.
        for (int v = 0; v < 4; v++) begin
            clear_monitor();
            bus.spi_cs_i = 1'b0;
            wait_clk(2);
            for (int b = 0; b < vecs[v].nbytes; b++) begin
                exp_b = (b == 0) ? vecs[v].data[15:8] : vecs[v].data[7:0];
                send_byte(exp_b, rd);
            end
            for (int k = 0; k < vecs[v].partial_bits; k++) send_bit(1'b0, c);
            wait_clk(6);
            bus.spi_cs_i = 1'b1;
            wait_clk(10);
            check($sformatf("v%0d_cs_start", v), n_start, 32'd1);
            check($sformatf("v%0d_cs_end", v), n_end, 32'd1);
            check($sformatf("v%0d_strobes", v), strobes.size(), vecs[v].exp_strobes);
            for (int k = 0; k < strobes.size() && k < vecs[v].exp_strobes; k++) begin
                exp_b = (k == 0) ? vecs[v].data[15:8] : vecs[v].data[7:0];
                check($sformatf("v%0d_byte%0d", v, k), {24'd0, strobes[k].data}, {24'd0, exp_b});
                check($sformatf("v%0d_first%0d", v, k), {31'd0, strobes[k].first}, (k == 0) ? 32'd1 : 32'd0);
            end
            check($sformatf("v%0d_hold", v), {24'd0, bus.rx_byte_o}, {24'd0, vecs[v].exp_hold});
        end

        // CS rise coinciding with the 8th SCK rise: CS wins, no byte.
        clear_monitor();
        bus.spi_cs_i = 1'b0;
        wait_clk(2);
        for (int k = 0; k < 7; k++) send_bit(1'b1, c);
        bus.spi_copi_i = 1'b1;
        wait_clk(4);
        bus.spi_sck_i = 1'b1;
        bus.spi_cs_i  = 1'b1;
        wait_clk(4);
        bus.spi_sck_i = 1'b0;
        wait_clk(10);
        check("collide_strobes", strobes.size(), 32'd0);
        check("collide_cs_end",  n_end, 32'd1);
        check("collide_hold",    {24'd0, bus.rx_byte_o}, 32'h81);

        // Asynchronous reset after 4 bits of 0xF0.
        bus.spi_cs_i = 1'b0;
        wait_clk(2);
        for (int k = 0; k < 4; k++) send_bit(1'b1, c);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("async_rst_rx_byte", {24'd0, bus.rx_byte_o}, 32'h00);
        check("async_rst_valid",   {31'd0, bus.rx_valid_o}, 32'd0);
        bus.spi_cs_i  = 1'b1;
        bus.spi_sck_i = 1'b0;
        wait_clk(3);
        reset = 1'b0;
        wait_clk(5);
        clear_monitor();
        bus.spi_cs_i = 1'b0;
        wait_clk(2);
        send_byte(8'h5A, rd);
        wait_clk(6);
        bus.spi_cs_i = 1'b1;
        wait_clk(10);
        check("post_rst_strobes", strobes.size(), 32'd1);
        if (strobes.size() > 0) begin
            check("post_rst_byte",  {24'd0, strobes[0].data}, 32'h5A);
            check("post_rst_first", {31'd0, strobes[0].first}, 32'd1);
        end
        check("post_rst_cs_start", n_start, 32'd1);

`ifdef SPI_CIPO_EN
        // Transmit 0xC3 then 0x0F over a two-byte transaction.
        clear_monitor();
        bus.tx_byte_i = 8'hC3;
        bus.spi_cs_i  = 1'b0;
        wait_clk(6);
        bus.tx_byte_i = 8'h0F;
        send_byte(8'h00, rd);
        send_byte(8'h00, rd2);
        wait_clk(6);
        bus.spi_cs_i = 1'b1;
        wait_clk(10);
        check("tx_byte0",   {24'd0, rd}, 32'hC3);
        check("tx_byte1",   {24'd0, rd2}, 32'h0F);
        check("tx_ready_n", n_ready, 32'd3);
        check("tx_cipo_end", {31'd0, bus.spi_cipo_o}, 32'd0);
`endif

        check("first_without_valid", n_orphan_first, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
